dino_game_state: RTL

- Game-state and collision stage directly downstream of the object controller.
- Consumes the dino vertical position, the three obstacle x-positions/active count, and the game tick.
- Decides when a run starts, detects dino/obstacle overlap, and ends the run.
- Maintains a 4-digit BCD score, and drives freeze/blink controls back to the object controller and the picture generators.

---
 rtl/dino_pkg.sv | 33 +++
 rtl/bcd_counter4.sv | 45 ++++
 rtl/dino_game_state.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dino_pkg.sv
// Shared types and default constants for the dino game-state stage.
package dino_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } state_e;

  localparam int unsigned DEF_DINO_X = 40;
  localparam int unsigned DEF_DINO_W = 20;
  localparam int unsigned DEF_OBS_W  = 16;
  localparam int unsigned DEF_OBS_H  = 24;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_DIGITS  = 4;

  // BCD magnitude compare, most significant digit first.
  function automatic logic bcd_gt(logic [15:0] a, logic [15:0] b);
    logic gt;
    logic decided;
    gt      = 1'b0;
    decided = 1'b0;
    for (int i = BCD_DIGITS - 1; i >= 0; i--) begin
      if (!decided && (a[i*BCD_DIGIT_W +: BCD_DIGIT_W] != b[i*BCD_DIGIT_W +: BCD_DIGIT_W])) begin
        gt      = a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > b[i*BCD_DIGIT_W +: BCD_DIGIT_W];
        decided = 1'b1;
      end
    end
    return gt;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD incrementer with synchronous clear; saturates at 9999.
module bcd_counter4
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc,
  output logic [15:0] count
);

  logic [15:0] count_q, count_d;
  logic        carry;

  always_comb begin
    count_d = count_q;
    carry   = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != 16'h9999)) begin
      carry = 1'b1;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
        if (carry) begin
          if (count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd9) begin
            count_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = 4'd0;
          end else begin
            count_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] = count_q[i*BCD_DIGIT_W +: BCD_DIGIT_W] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/dino_game_state.sv
// Game-state FSM, collision detect and BCD score for the dino game.
// Optional HISCORE_EN adds a high-score register and hiscore_bcd output.
module dino_game_state
  import dino_pkg::*;
#(
  parameter int unsigned DINO_X      = DEF_DINO_X,
  parameter int unsigned DINO_W      = DEF_DINO_W,
  parameter int unsigned OBS_W       = DEF_OBS_W,
  parameter int unsigned OBS_H       = DEF_OBS_H,
  parameter int unsigned SCORE_DIV   = 6,
  parameter int unsigned BLINK_TICKS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        game_clk,
  input  logic        start,
  input  logic [8:0]  dino_pos,
  input  logic [8:0]  danger_pos1,
  input  logic [8:0]  danger_pos2,
  input  logic [8:0]  danger_pos3,
  input  logic [1:0]  danger_num,
  output logic        running,
  output logic        game_over,
  output logic        freeze,
  output logic        blink,
  output logic [15:0] score_bcd
`ifdef HISCORE_EN
  ,
  output logic [15:0] hiscore_bcd
`endif
);

  localparam int unsigned DivW   = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [DivW-1:0]   DivMax   = DivW'(SCORE_DIV - 1);
  localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_TICKS - 1);
  localparam logic [9:0] HitL = 10'(DINO_X);
  localparam logic [9:0] HitR = 10'(DINO_X + DINO_W);
  localparam logic [9:0] ObsW = 10'(OBS_W);
  localparam logic [8:0] ObsH = 9'(OBS_H);

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [BlinkW-1:0]   bcnt_q, bcnt_d;
  logic                blink_q, blink_d;
  logic                game_clk_q;
  logic                hit_q, hit_d;
  logic                tick;
  logic                score_clr, score_inc;

  assign tick = game_clk & ~game_clk_q;

  // 10-bit sums so positions near 511 cannot wrap into a false hit.
  function automatic logic x_overlap(logic [8:0] pos);
    return ({1'b0, pos} < HitR) && (({1'b0, pos} + ObsW) > HitL);
  endfunction

  always_comb begin
    hit_d = 1'b0;
    if ((danger_num >= 2'd1) && x_overlap(danger_pos1)) hit_d = 1'b1;
    if ((danger_num >= 2'd2) && x_overlap(danger_pos2)) hit_d = 1'b1;
    if ((danger_num == 2'd3) && x_overlap(danger_pos3)) hit_d = 1'b1;
    hit_d = hit_d & (dino_pos < ObsH);
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bcnt_d    = bcnt_q;
    blink_d   = blink_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StRun;
          div_d     = '0;
          score_clr = 1'b1;
        end
      end
      StRun: begin
        // A colliding tick ends the run and is not scored; start is ignored here.
        if (tick) begin
          if (hit_q) begin
            state_d = StOver;
            bcnt_d  = '0;
            blink_d = 1'b0;
          end else if (div_q == DivMax) begin
            div_d     = '0;
            score_inc = 1'b1;
          end else begin
            div_d = div_q + DivW'(1);
          end
        end
      end
      StOver: begin
        if (start) begin
          state_d   = StRun;
          div_d     = '0;
          bcnt_d    = '0;
          blink_d   = 1'b0;
          score_clr = 1'b1;
        end else if (tick) begin
          if (bcnt_q == BlinkMax) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end else begin
            bcnt_d = bcnt_q + BlinkW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      bcnt_q     <= '0;
      blink_q    <= 1'b0;
      game_clk_q <= 1'b0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bcnt_q     <= bcnt_d;
      blink_q    <= blink_d;
      game_clk_q <= game_clk;
      hit_q      <= hit_d;
    end
  end

  bcd_counter4 u_score (
    .clk   (clk),
    .rst   (rst),
    .clr   (score_clr),
    .inc   (score_inc),
    .count (score_bcd)
  );

`ifdef HISCORE_EN
  logic [15:0] hiscore_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hiscore_q <= '0;
    end else if ((state_q == StRun) && (state_d == StOver) && bcd_gt(score_bcd, hiscore_q)) begin
      hiscore_q <= score_bcd;
    end
  end

  assign hiscore_bcd = hiscore_q;
`endif

  assign running   = (state_q == StRun);
  assign game_over = (state_q == StOver);
  assign freeze    = (state_q != StRun);
  assign blink     = blink_q;

endmodule
